// File: rtl/jdquant_pkg.sv
// rtl/jdquant_pkg.sv - shared constants, state encoding and zigzag table for the dezigzag stage
package jdquant_pkg;

    localparam int DEFAULT_WIDTH    = 16;
    localparam int FIXED_BLOCK_LOG2 = 6;

    typedef enum logic [1:0] {
        FILL    = 2'd0,
        DRAIN   = 2'd1,
        EOS_OUT = 2'd2,
        DONE    = 2'd3
    } state_e;

    // Natural (row-major) position of the k-th coefficient in zigzag order.
    localparam logic [5:0] ZZ2NAT [0:63] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

endpackage

// File: rtl/jdquant_dezigzag_bank.sv
// rtl/jdquant_dezigzag_bank.sv - 64-entry coefficient bank with written-mask; unwritten entries read as 0
module jdquant_dezigzag_bank
    import jdquant_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             we_i,
    input  logic [5:0]       waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             clr_i,
    input  logic [5:0]       raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [0:63];
    logic [63:0]      mask_q;
    logic [63:0]      mask_d;

    always_comb begin
        mask_d = mask_q;
        if (clr_i) begin
            mask_d = '0;
        end
        if (we_i) begin
            mask_d[waddr_i] = 1'b1;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            mask_q <= '0;
        end else begin
            mask_q <= mask_d;
        end
    end

    // Data needs no reset: the mask decides whether an entry is visible.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mask_q[raddr_i] ? mem_q[raddr_i] : '0;

endmodule

// File: rtl/jdquant_dezigzag.sv
// rtl/jdquant_dezigzag.sv - zigzag-to-natural reorder of 8x8 coefficient blocks
// JDQUANT_DEZIGZAG_PINGPONG_EN selects two banks so filling overlaps draining.
module jdquant_dezigzag
    import jdquant_pkg::*;
#(
    parameter int WIDTH      = DEFAULT_WIDTH,
    parameter int BLOCK_LOG2 = FIXED_BLOCK_LOG2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] inStream_d,
    input  logic             inStream_e,
    input  logic             inStream_v,
    output logic             inStream_b,
    output logic [WIDTH-1:0] outStream_d,
    output logic             outStream_e,
    output logic             outStream_v,
    input  logic             outStream_b
);

    if (BLOCK_LOG2 != FIXED_BLOCK_LOG2) begin : g_bad_block_log2
        $error("jdquant_dezigzag supports only BLOCK_LOG2 = 6");
    end

    logic       in_xfer;
    logic       out_xfer;
    logic [5:0] wr_idx_q, wr_idx_d;
    logic [5:0] rd_idx_q, rd_idx_d;
    logic       eos_pending_q, eos_pending_d;

    assign in_xfer  = inStream_v && !inStream_b;
    assign out_xfer = outStream_v && !outStream_b;

`ifdef JDQUANT_DEZIGZAG_PINGPONG_EN

    // Banks are filled and drained strictly in alternation, so the oldest
    // full bank is always the one rd_bank_q points at.
    logic             wr_bank_q, wr_bank_d;
    logic             rd_bank_q, rd_bank_d;
    logic [1:0]       full_q, full_d;
    logic [1:0]       we_vec, clr_vec;
    logic [WIDTH-1:0] rdata_vec [0:1];
    state_e           mode;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        jdquant_dezigzag_bank #(.WIDTH(WIDTH)) u_bank (
            .clk_i   (clock),
            .rst_i   (reset),
            .we_i    (we_vec[b]),
            .waddr_i (ZZ2NAT[wr_idx_q]),
            .wdata_i (inStream_d),
            .clr_i   (clr_vec[b]),
            .raddr_i (rd_idx_q),
            .rdata_o (rdata_vec[b])
        );
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            wr_idx_q      <= '0;
            rd_idx_q      <= '0;
            eos_pending_q <= 1'b0;
            wr_bank_q     <= 1'b0;
            rd_bank_q     <= 1'b0;
            full_q        <= '0;
        end else begin
            wr_idx_q      <= wr_idx_d;
            rd_idx_q      <= rd_idx_d;
            eos_pending_q <= eos_pending_d;
            wr_bank_q     <= wr_bank_d;
            rd_bank_q     <= rd_bank_d;
            full_q        <= full_d;
        end
    end

    always_comb begin
        wr_idx_d      = wr_idx_q;
        rd_idx_d      = rd_idx_q;
        eos_pending_d = eos_pending_q;
        wr_bank_d     = wr_bank_q;
        rd_bank_d     = rd_bank_q;
        full_d        = full_q;
        we_vec        = '0;
        clr_vec       = '0;
        if (in_xfer) begin
            if (inStream_e) begin
                eos_pending_d = 1'b1;
                if (wr_idx_q != 6'd0) begin
                    full_d[wr_bank_q] = 1'b1;
                    wr_bank_d         = ~wr_bank_q;
                    wr_idx_d          = '0;
                end
            end else begin
                we_vec[wr_bank_q] = 1'b1;
                wr_idx_d          = wr_idx_q + 6'd1;
                if (wr_idx_q == 6'd63) begin
                    full_d[wr_bank_q] = 1'b1;
                    wr_bank_d         = ~wr_bank_q;
                end
            end
        end
        if (out_xfer) begin
            if (full_q[rd_bank_q]) begin
                rd_idx_d = rd_idx_q + 6'd1;
                if (rd_idx_q == 6'd63) begin
                    full_d[rd_bank_q]  = 1'b0;
                    clr_vec[rd_bank_q] = 1'b1;
                    rd_bank_d          = ~rd_bank_q;
                end
            end else begin
                eos_pending_d = 1'b0;
            end
        end
    end

    always_comb begin
        mode = FILL;
        if (full_q[rd_bank_q]) begin
            mode = DRAIN;
        end else if (eos_pending_q) begin
            mode = EOS_OUT;
        end
        inStream_b  = full_q[wr_bank_q] || eos_pending_q;
        outStream_v = (mode == DRAIN) || (mode == EOS_OUT);
        outStream_e = (mode == EOS_OUT);
        outStream_d = (mode == DRAIN) ? rdata_vec[rd_bank_q] : '0;
    end

`else

    state_e           state_q, state_d;
    logic             bank_we;
    logic             bank_clr;
    logic [WIDTH-1:0] bank_rdata;

    jdquant_dezigzag_bank #(.WIDTH(WIDTH)) u_bank (
        .clk_i   (clock),
        .rst_i   (reset),
        .we_i    (bank_we),
        .waddr_i (ZZ2NAT[wr_idx_q]),
        .wdata_i (inStream_d),
        .clr_i   (bank_clr),
        .raddr_i (rd_idx_q),
        .rdata_o (bank_rdata)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q       <= FILL;
            wr_idx_q      <= '0;
            rd_idx_q      <= '0;
            eos_pending_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            wr_idx_q      <= wr_idx_d;
            rd_idx_q      <= rd_idx_d;
            eos_pending_q <= eos_pending_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        wr_idx_d      = wr_idx_q;
        rd_idx_d      = rd_idx_q;
        eos_pending_d = eos_pending_q;
        bank_we       = 1'b0;
        bank_clr      = 1'b0;
        case (state_q)
            FILL, DONE: begin
                if (in_xfer) begin
                    if (inStream_e) begin
                        if (wr_idx_q == 6'd0) begin
                            state_d = EOS_OUT;
                        end else begin
                            // Truncated block: drain it padded with zeros first.
                            eos_pending_d = 1'b1;
                            rd_idx_d      = '0;
                            state_d       = DRAIN;
                        end
                    end else begin
                        bank_we  = 1'b1;
                        wr_idx_d = wr_idx_q + 6'd1;
                        if (wr_idx_q == 6'd63) begin
                            rd_idx_d = '0;
                            state_d  = DRAIN;
                        end else begin
                            state_d = FILL;
                        end
                    end
                end
            end
            DRAIN: begin
                if (out_xfer) begin
                    rd_idx_d = rd_idx_q + 6'd1;
                    if (rd_idx_q == 6'd63) begin
                        bank_clr      = 1'b1;
                        wr_idx_d      = '0;
                        eos_pending_d = 1'b0;
                        state_d       = eos_pending_q ? EOS_OUT : FILL;
                    end
                end
            end
            EOS_OUT: begin
                if (out_xfer) begin
                    state_d = DONE;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_comb begin
        inStream_b  = (state_q == DRAIN) || (state_q == EOS_OUT);
        outStream_v = (state_q == DRAIN) || (state_q == EOS_OUT);
        outStream_e = (state_q == EOS_OUT);
        outStream_d = (state_q == DRAIN) ? bank_rdata : '0;
    end

`endif

endmodule

// File: tb/tb_jdquant_dezigzag.sv
// tb/tb_jdquant_dezigzag.sv - scoreboard bench for the zigzag-to-natural reorder stage
module tb_jdquant_dezigzag;

    localparam int W = 16;

    logic         clock = 1'b0;
    logic         reset = 1'b1;
    logic [W-1:0] in_d;
    logic         in_e;
    logic         in_v;
    logic         in_b;
    logic [W-1:0] out_d;
    logic         out_e;
    logic         out_v;
    logic         out_b;

    int           errors = 0;
    int           checks = 0;
    int           ob_mode = 0;
    int           in_stalls = 0;
    logic [16:0]  sb [$];
    logic         prev_stall = 1'b0;
    logic [16:0]  prev_tok = '0;
    logic [W-1:0] blk [64];

    int zz [64] = '{
         0,  1,  8, 16,  9,  2,  3, 10, 17, 24, 32, 25, 18, 11,  4,  5,
        12, 19, 26, 33, 40, 48, 41, 34, 27, 20, 13,  6,  7, 14, 21, 28,
        35, 42, 49, 56, 57, 50, 43, 36, 29, 22, 15, 23, 30, 37, 44, 51,
        58, 59, 52, 45, 38, 31, 39, 46, 53, 60, 61, 54, 47, 55, 62, 63
    };

    always #5 clock = ~clock;

    jdquant_dezigzag #(.WIDTH(W), .BLOCK_LOG2(6)) dut (
        .clock       (clock),
        .reset       (reset),
        .inStream_d  (in_d),
        .inStream_e  (in_e),
        .inStream_v  (in_v),
        .inStream_b  (in_b),
        .outStream_d (out_d),
        .outStream_e (out_e),
        .outStream_v (out_v),
        .outStream_b (out_b)
    );

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(posedge clock) begin
        #1;
        case (ob_mode)
            1:       out_b = ~out_b;
            2:       out_b = 1'($urandom_range(0, 1));
            default: out_b = 1'b0;
        endcase
    end

    always @(negedge clock) begin
        if (reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk_eq("hold", {15'd0, out_e, out_d}, {15'd0, prev_tok});
            end
            if (out_v && !out_b) begin
                chk_eq("sb_nonempty", 32'(sb.size() != 0), 1);
                if (sb.size() != 0) begin
                    chk_eq("out_tok", {15'd0, out_e, out_d}, {15'd0, sb.pop_front()});
                end
            end
            prev_stall = out_v && out_b;
            prev_tok   = {out_e, out_d};
        end
    end

    task automatic put(input logic e, input logic [W-1:0] d);
        bit acc;
        int n;
        in_v = 1'b1;
        in_e = e;
        in_d = d;
        n    = 0;
        do begin
            @(negedge clock);
            acc = !in_b;
            @(posedge clock);
            #1;
            n++;
        end while (!acc && n < 400);
        if (!acc) chk_eq("put_timeout", 32'(acc), 1);
        if (n > 1) in_stalls += n - 1;
        in_v = 1'b0;
        in_e = 1'b0;
    endtask

    task automatic push_expected(input int count, input bit eos);
        logic [W-1:0] nat [64];
        for (int n = 0; n < 64; n++) nat[n] = '0;
        for (int k = 0; k < count; k++) nat[zz[k]] = blk[k];
        if (count > 0) begin
            for (int n = 0; n < 64; n++) sb.push_back({1'b0, nat[n]});
        end
        if (eos) sb.push_back({1'b1, 16'h0});
    endtask

    task automatic feed(input int count, input bit eos, input bit gaps);
        for (int k = 0; k < count; k++) begin
            put(1'b0, blk[k]);
            if (gaps && $urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 2)) @(posedge clock);
                #1;
            end
        end
        if (eos) put(1'b1, '0);
    endtask

    task automatic wait_empty(input string tag, output int n);
        n = 0;
        while (sb.size() != 0 && n < 1000) begin
            @(posedge clock);
            #1;
            n++;
        end
        chk_eq(tag, sb.size(), 0);
    endtask

    initial begin
        int n;
        in_v  = 1'b0;
        in_e  = 1'b0;
        in_d  = '0;
        out_b = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        chk_eq("rst_in_b", 32'(in_b), 0);
        chk_eq("rst_out_v", 32'(out_v), 0);
        chk_eq("rst_out_e", 32'(out_e), 0);
        chk_eq("rst_out_d", 32'(out_d), 0);
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;

        // EOS as the very first token
        push_expected(0, 1'b1);
        put(1'b1, '0);
        wait_empty("eos_only", n);
        repeat (3) @(posedge clock);
        #1;
        chk_eq("eos_only_idle_b", 32'(in_b), 0);
        chk_eq("eos_only_idle_v", 32'(out_v), 0);

        // Full block, value = zigzag index, no stalls
        for (int k = 0; k < 64; k++) blk[k] = W'(k);
        push_expected(64, 1'b0);
        feed(64, 1'b0, 1'b0);
        chk_eq("lat_v", 32'(out_v), 1);
        chk_eq("lat_d", 32'(out_d), 0);
`ifndef JDQUANT_DEZIGZAG_PINGPONG_EN
        chk_eq("drain_in_b", 32'(in_b), 1);
`endif
        wait_empty("full_drain", n);
        chk_eq("full_cycles", n, 64);

        // Same block under alternating back-pressure
        ob_mode = 1;
        push_expected(64, 1'b0);
        feed(64, 1'b0, 1'b0);
        wait_empty("bp_drain", n);
        chk_eq("bp_cycles_range", 32'(n >= 126 && n <= 130), 1);
        ob_mode = 0;
        repeat (2) @(posedge clock);
        #1;

        // Random data, random input gaps and random back-pressure
        for (int k = 0; k < 64; k++) blk[k] = W'($urandom);
        ob_mode = 2;
        push_expected(64, 1'b0);
        feed(64, 1'b0, 1'b1);
        wait_empty("rand_drain", n);
        ob_mode = 0;
        repeat (2) @(posedge clock);
        #1;

        // Truncated block then EOS
        for (int k = 0; k < 64; k++) blk[k] = W'(100 + k);
        push_expected(10, 1'b1);
        feed(10, 1'b1, 1'b0);
        wait_empty("trunc_drain", n);
        repeat (3) @(posedge clock);
        #1;
        chk_eq("trunc_idle_b", 32'(in_b), 0);
        chk_eq("trunc_idle_v", 32'(out_v), 0);

        // Reset in the middle of a block
        for (int k = 0; k < 30; k++) put(1'b0, W'(500 + k));
        reset = 1'b1;
        #1;
        chk_eq("midrst_in_b", 32'(in_b), 0);
        chk_eq("midrst_out_v", 32'(out_v), 0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        repeat (2) @(posedge clock);
        #1;
        chk_eq("post_rst_idle_v", 32'(out_v), 0);
        for (int k = 0; k < 64; k++) blk[k] = W'(7);
        push_expected(64, 1'b0);
        feed(64, 1'b0, 1'b0);
        wait_empty("post_rst_drain", n);

`ifdef JDQUANT_DEZIGZAG_PINGPONG_EN
        // Two back-to-back blocks with no input stall
        in_stalls = 0;
        for (int k = 0; k < 64; k++) blk[k] = W'(k + 1000);
        push_expected(64, 1'b0);
        feed(64, 1'b0, 1'b0);
        for (int k = 0; k < 64; k++) blk[k] = W'(k + 2000);
        push_expected(64, 1'b0);
        feed(64, 1'b0, 1'b0);
        chk_eq("pp_no_stall", in_stalls, 0);
        wait_empty("pp_drain", n);
        chk_eq("pp_contig", n, 64);
`endif

        repeat (5) @(posedge clock);
        #1;
        chk_eq("final_idle_v", 32'(out_v), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

endmodule
